// File: rtl/csr_pkg.sv
// csr_pkg -- shared definitions for the machine-mode CSR file.
//   CSR address constants, the CSR read-modify-write op encoding and the
//   bit positions of the optional mcountinhibit register.
package csr_pkg;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_SCRATCH_BASE  = 12'h7C0;

  // Encodings match the csr_control field driven by the decoder.
  typedef enum logic [1:0] {
    CSR_PASS  = 2'b00,
    CSR_SET   = 2'b01,
    CSR_CLEAR = 2'b10,
    CSR_RSVD  = 2'b11
  } csr_op_t;

  localparam int MCI_CY = 0;
  localparam int MCI_IR = 2;

endpackage

// File: rtl/csr_file_if.sv
// csr_file_if -- execute-stage CSR access bus.
//   master (execute stage): drives csr_valid_i, stall_i, csr_control_i,
//     csr_addr_i, operand_a_i, src_is_zero_i; receives csr_rdata_o and
//     csr_illegal_o.
//   slave (csr_file): the reverse.
//   Signal suffixes are from the CSR file's point of view.
interface csr_file_if #(
  parameter int WIDTH = 32
) ();
  logic             csr_valid_i;
  logic             stall_i;
  logic [1:0]       csr_control_i;
  logic [11:0]      csr_addr_i;
  logic [WIDTH-1:0] operand_a_i;
  logic             src_is_zero_i;
  logic [WIDTH-1:0] csr_rdata_o;
  logic             csr_illegal_o;

  modport master (
    output csr_valid_i, stall_i, csr_control_i, csr_addr_i, operand_a_i,
           src_is_zero_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_valid_i, stall_i, csr_control_i, csr_addr_i, operand_a_i,
           src_is_zero_i,
    output csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_counter.sv
// csr_counter -- free-running hardware counter with software write port.
//   clk_i, reset_n_i : clock, asynchronous active-low reset (count -> 0)
//   inc_i            : add one this cycle
//   wr_lo_i/wr_hi_i  : software write of the low/high WIDTH-bit half
//   wdata_i          : software write data
//   count_o          : current COUNTER_WIDTH-bit count
// COUNTER_WIDTH is WIDTH or 2*WIDTH; in the single-half form wr_hi_i is
// ignored. A software write always beats the increment of the half it
// targets, and the carry between halves is dropped whenever either half
// is written in that cycle.
module csr_counter #(
  parameter int WIDTH         = 32,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     inc_i,
  input  logic                     wr_lo_i,
  input  logic                     wr_hi_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [COUNTER_WIDTH-1:0] count_o
);

  if (COUNTER_WIDTH == 2 * WIDTH) begin : g_split
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic             carry;

    always_comb begin
      carry = inc_i & (&lo_q);
      lo_d  = lo_q + {{(WIDTH-1){1'b0}}, inc_i};
      hi_d  = hi_q + {{(WIDTH-1){1'b0}}, carry};
      // Writing lo: hi holds, the wrap carry is lost.
      if (wr_lo_i) begin
        lo_d = wdata_i;
        hi_d = hi_q;
      end
      // Writing hi: lo still increments, its carry is overridden.
      if (wr_hi_i) begin
        hi_d = wdata_i;
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        lo_q <= '0;
        hi_q <= '0;
      end else begin
        lo_q <= lo_d;
        hi_q <= hi_d;
      end
    end

    assign count_o = {hi_q, lo_q};
  end else begin : g_flat
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     unused_wr_hi;

    assign unused_wr_hi = wr_hi_i;

    always_comb begin
      cnt_d = cnt_q + {{(COUNTER_WIDTH-1){1'b0}}, inc_i};
      if (wr_lo_i) begin
        cnt_d = wdata_i;
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign count_o = cnt_q;
  end

endmodule

// File: rtl/csr_file.sv
// csr_file -- machine-mode CSR storage and read-modify-write unit.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   instr_retired_i  : one instruction retired this cycle (minstret tick)
//   bus (slave)      : execute-stage CSR access; csr_rdata_o returns the
//                      pre-edge value combinationally, csr_illegal_o flags
//                      bad accesses, the modified value commits at the edge.
// Holds mcycle/minstret (with read-only cycle/instret aliases) and
// NUM_SCRATCH R/W scratch CSRs at 0x7C0 upward.
// Optional feature macro CSR_COUNTER_INHIBIT_EN adds mcountinhibit (0x320)
// with CY (bit 0) and IR (bit 2) freezing mcycle/minstret.
module csr_file
  import csr_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_SCRATCH   = 4
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         instr_retired_i,
  csr_file_if.slave    bus
);

  localparam bit         HI_EN     = (COUNTER_WIDTH == 2 * WIDTH);
  localparam logic [4:0] NUM_SCR_W = 5'(NUM_SCRATCH);

  function automatic logic [WIDTH-1:0] csr_modify(input csr_op_t          op,
                                                  input logic [WIDTH-1:0] old_v,
                                                  input logic [WIDTH-1:0] a);
    case (op)
      CSR_SET:   return old_v | a;
      CSR_CLEAR: return old_v & ~a;
      default:   return a;
    endcase
  endfunction

  csr_op_t                  op;
  logic                     hit, ro, illegal, we;
  logic [WIDTH-1:0]         old_val, wdata;
  logic [COUNTER_WIDTH-1:0] mcycle_q, minstret_q;
  logic [2*WIDTH-1:0]       mcycle_ext, minstret_ext;
  logic                     cy_inc, ir_inc;
  logic                     scr_hit;
  logic [3:0]               scr_idx;
  logic [WIDTH-1:0]         scratch_rd [16];

  assign op = csr_op_t'(bus.csr_control_i);

  // Counters seen as two halves regardless of COUNTER_WIDTH; the high half
  // is only reachable when HI_EN.
  if (HI_EN) begin : g_ext_split
    assign mcycle_ext   = mcycle_q;
    assign minstret_ext = minstret_q;
  end else begin : g_ext_flat
    assign mcycle_ext   = {{WIDTH{1'b0}}, mcycle_q};
    assign minstret_ext = {{WIDTH{1'b0}}, minstret_q};
  end

  assign scr_idx = bus.csr_addr_i[3:0];
  assign scr_hit = (bus.csr_addr_i[11:4] == CSR_SCRATCH_BASE[11:4]) &&
                   ({1'b0, scr_idx} < NUM_SCR_W);

`ifdef CSR_COUNTER_INHIBIT_EN
  logic             cy_q, ir_q;
  logic [WIDTH-1:0] mci_rd;

  always_comb begin
    mci_rd         = '0;
    mci_rd[MCI_CY] = cy_q;
    mci_rd[MCI_IR] = ir_q;
  end

  // Registered, so a write only freezes counting from the following cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cy_q <= 1'b0;
      ir_q <= 1'b0;
    end else if (we && bus.csr_addr_i == CSR_MCOUNTINHIBIT) begin
      cy_q <= wdata[MCI_CY];
      ir_q <= wdata[MCI_IR];
    end
  end

  assign cy_inc = ~cy_q;
  assign ir_inc = instr_retired_i & ~ir_q;
`else
  assign cy_inc = 1'b1;
  assign ir_inc = instr_retired_i;
`endif

  // Address decode and old-value read
  always_comb begin
    hit     = 1'b0;
    ro      = 1'b0;
    old_val = '0;
    case (bus.csr_addr_i)
      CSR_MCYCLE:    begin hit = 1'b1;  old_val = mcycle_ext[WIDTH-1:0];           end
      CSR_MCYCLEH:   begin hit = HI_EN; old_val = mcycle_ext[2*WIDTH-1:WIDTH];     end
      CSR_MINSTRET:  begin hit = 1'b1;  old_val = minstret_ext[WIDTH-1:0];         end
      CSR_MINSTRETH: begin hit = HI_EN; old_val = minstret_ext[2*WIDTH-1:WIDTH];   end
      CSR_CYCLE:     begin hit = 1'b1;  ro = 1'b1; old_val = mcycle_ext[WIDTH-1:0];         end
      CSR_CYCLEH:    begin hit = HI_EN; ro = 1'b1; old_val = mcycle_ext[2*WIDTH-1:WIDTH];   end
      CSR_INSTRET:   begin hit = 1'b1;  ro = 1'b1; old_val = minstret_ext[WIDTH-1:0];       end
      CSR_INSTRETH:  begin hit = HI_EN; ro = 1'b1; old_val = minstret_ext[2*WIDTH-1:WIDTH]; end
`ifdef CSR_COUNTER_INHIBIT_EN
      CSR_MCOUNTINHIBIT: begin hit = 1'b1; old_val = mci_rd; end
`endif
      default: begin
        if (scr_hit) begin
          hit     = 1'b1;
          old_val = scratch_rd[scr_idx];
        end
      end
    endcase
  end

  // Read-only targets are legal only as a pure read (SET/CLEAR of zero).
  assign illegal = bus.csr_valid_i &
                   (~hit | (op == CSR_RSVD) |
                    (ro & ((op == CSR_PASS) | ~bus.src_is_zero_i)));

  assign we = bus.csr_valid_i & ~bus.stall_i & ~illegal &
              ~((op != CSR_PASS) & bus.src_is_zero_i);

  assign wdata             = csr_modify(op, old_val, bus.operand_a_i);
  assign bus.csr_rdata_o   = (bus.csr_valid_i & hit) ? old_val : '0;
  assign bus.csr_illegal_o = illegal;

  csr_counter #(
    .WIDTH         (WIDTH),
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_mcycle (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (cy_inc),
    .wr_lo_i   (we && bus.csr_addr_i == CSR_MCYCLE),
    .wr_hi_i   (we && bus.csr_addr_i == CSR_MCYCLEH),
    .wdata_i   (wdata),
    .count_o   (mcycle_q)
  );

  csr_counter #(
    .WIDTH         (WIDTH),
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_minstret (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (ir_inc),
    .wr_lo_i   (we && bus.csr_addr_i == CSR_MINSTRET),
    .wr_hi_i   (we && bus.csr_addr_i == CSR_MINSTRETH),
    .wdata_i   (wdata),
    .count_o   (minstret_q)
  );

  // Scratch CSRs: a fixed 16-entry read view, only NUM_SCRATCH backed by flops.
  for (genvar g = 0; g < 16; g++) begin : g_scr
    if (g < NUM_SCRATCH) begin : g_impl
      logic [WIDTH-1:0] scr_q;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          scr_q <= '0;
        end else if (we && scr_hit && scr_idx == 4'(g)) begin
          scr_q <= wdata;
        end
      end

      assign scratch_rd[g] = scr_q;
    end else begin : g_none
      assign scratch_rd[g] = '0;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file -- directed bench for csr_file (default parameters).
//   Table of single-cycle accesses against scratch/read-only/unimplemented
//   addresses, plus hand-written sequences for counter wrap, write-vs-
//   increment, minstret, asynchronous reset and (when CSR_COUNTER_INHIBIT_EN
//   is defined) mcountinhibit.
module tb_csr_file;
  import csr_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic retire;
  int   checks = 0;
  int   errors = 0;

  csr_file_if #(.WIDTH(32)) bus ();

  csr_file #(
    .WIDTH         (32),
    .COUNTER_WIDTH (64),
    .NUM_SCRATCH   (4)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .instr_retired_i (retire),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        stall;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] a;
    logic        zero;
    logic [31:0] exp_rd;
    logic        chk_rd;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic s, input logic [1:0] op,
                     input logic [11:0] ad, input logic [31:0] a,
                     input logic z);
    bus.csr_valid_i   = v;
    bus.stall_i       = s;
    bus.csr_control_i = op;
    bus.csr_addr_i    = ad;
    bus.operand_a_i   = a;
    bus.src_is_zero_i = z;
  endtask

  task automatic chk(input string nm, input logic [31:0] er,
                     input logic crd, input logic ei);
    #1;
    if (crd) begin
      checks++;
      if (bus.csr_rdata_o !== er) begin
        errors++;
        $display("FAIL %s rdata got %h expected %h", nm, bus.csr_rdata_o, er);
      end
    end
    checks++;
    if (bus.csr_illegal_o !== ei) begin
      errors++;
      $display("FAIL %s illegal got %b expected %b", nm, bus.csr_illegal_o, ei);
    end
  endtask

  // Pure read: SET with a zero source never writes.
  task automatic rd(input string nm, input logic [11:0] ad, input logic [31:0] er);
    drv(1'b1, 1'b0, CSR_SET, ad, 32'h0, 1'b1);
    chk(nm, er, 1'b1, 1'b0);
  endtask

  task automatic wr(input logic [11:0] ad, input logic [31:0] a);
    drv(1'b1, 1'b0, CSR_PASS, ad, a, 1'b0);
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, CSR_PASS, 12'h000, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //            valid stall op         addr    a             zero exp_rd        chk  ill
    vecs[0]  = '{1'b1, 1'b0, CSR_PASS,  12'h7C1, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, CSR_SET,   12'h7C1, 32'h000000F0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, CSR_CLEAR, 12'h7C1, 32'hDEAD0000, 1'b0, 32'hDEADBEFF, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, CSR_SET,   12'h7C1, 32'h00000000, 1'b1, 32'h0000BEFF, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, CSR_PASS,  12'hC02, 32'h00001234, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, CSR_SET,   12'hC02, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, CSR_SET,   12'hC02, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, CSR_PASS,  12'h123, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, CSR_RSVD,  12'h7C1, 32'h00001111, 1'b0, 32'h00000000, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, CSR_SET,   12'h7C1, 32'h00000000, 1'b1, 32'h0000BEFF, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, CSR_PASS,  12'h7C0, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, CSR_SET,   12'h7C0, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, CSR_PASS,  12'h7C0, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, CSR_SET,   12'h7C0, 32'h00000000, 1'b1, 32'h00000005, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, CSR_PASS,  12'h7C3, 32'h0000A5A5, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, CSR_SET,   12'h7C3, 32'h00000000, 1'b1, 32'h0000A5A5, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, CSR_SET,   12'h7C4, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 1'b0, CSR_CLEAR, 12'h7C0, 32'h00000000, 1'b1, 32'h00000005, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, CSR_SET,   12'h7C0, 32'h00000000, 1'b1, 32'h00000005, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, CSR_SET,   12'h7C0, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b0, CSR_SET,   12'hB80, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 1'b1, CSR_PASS,  12'hC02, 32'h00000009, 1'b0, 32'h00000000, 1'b1, 1'b1};

    // Reset state
    rst_n  = 1'b0;
    retire = 1'b0;
    idle();
    step();
    rd("rst_mcycle", 12'hB00, 32'h0);
    rd("rst_scratch", 12'h7C2, 32'h0);
    drv(1'b0, 1'b0, CSR_PASS, 12'h123, 32'h5, 1'b0);
    chk("rst_novalid", 32'h0, 1'b1, 1'b0);
    idle();
    step();
    rst_n = 1'b1;

    // Ten idle cycles -> mcycle == 10, visible through both aliases
    repeat (10) step();
    rd("mcycle_10", 12'hB00, 32'd10);
    rd("cycle_10", 12'hC00, 32'd10);
    rd("cycleh_0", 12'hC80, 32'd0);
    rd("instret_0", 12'hC02, 32'd0);

    // Table-driven single-cycle accesses
    for (int i = 0; i < 22; i++) begin
      step();
      drv(vecs[i].valid, vecs[i].stall, vecs[i].op, vecs[i].addr,
          vecs[i].a, vecs[i].zero);
      chk($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].chk_rd, vecs[i].exp_ill);
    end

    // mcycle lo wrap carries into hi one cycle after the write
    step();
    wr(12'hB00, 32'hFFFFFFFF);
    step();
    rd("wrap_lo_ff", 12'hB00, 32'hFFFFFFFF);
    rd("wrap_hi_0", 12'hB80, 32'h0);
    step();
    rd("wrap_lo_0", 12'hB00, 32'h0);
    rd("wrap_hi_1", 12'hB80, 32'h1);
    rd("wrap_cych_1", 12'hC80, 32'h1);
    // Write to hi: lo keeps counting
    wr(12'hB80, 32'h7);
    chk("wr_hi_old", 32'h1, 1'b1, 1'b0);
    step();
    rd("wr_hi_lo", 12'hB00, 32'h1);
    rd("wr_hi_hi", 12'hB80, 32'h7);
    // Write to lo at the wrap point: carry into hi dropped
    wr(12'hB00, 32'hFFFFFFFF);
    step();
    wr(12'hB00, 32'h10);
    step();
    rd("drop_lo", 12'hB00, 32'h10);
    rd("drop_hi", 12'hB80, 32'h7);
    // Write to hi at the wrap point: lo wraps, hi takes write data
    wr(12'hB00, 32'hFFFFFFFF);
    step();
    wr(12'hB80, 32'h20);
    step();
    rd("hiwr_lo", 12'hB00, 32'h0);
    rd("hiwr_hi", 12'hB80, 32'h20);

    // minstret counts retirements; write wins over increment
    idle();
    retire = 1'b1;
    repeat (3) step();
    retire = 1'b0;
    rd("minstret_3", 12'hB02, 32'd3);
    rd("instret_3", 12'hC02, 32'd3);
    rd("instreth_0", 12'hC82, 32'd0);
    wr(12'hB02, 32'd100);
    retire = 1'b1;
    step();
    rd("minstret_wr", 12'hB02, 32'd100);
    step();
    retire = 1'b0;
    rd("minstret_101", 12'hB02, 32'd101);

    // Asynchronous reset mid-cycle discards the pending write
    step();
    wr(12'h7C0, 32'h77);
    #2;
    rst_n = 1'b0;
    chk("async_rst", 32'h0, 1'b1, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    rd("post_rst_scr0", 12'h7C0, 32'h0);
    rd("post_rst_scr1", 12'h7C1, 32'h0);
    rd("post_rst_scr3", 12'h7C3, 32'h0);
    rd("post_rst_mcyc", 12'hB00, 32'h0);
    rd("post_rst_mcych", 12'hB80, 32'h0);
    rd("post_rst_minst", 12'hB02, 32'h0);

`ifdef CSR_COUNTER_INHIBIT_EN
    step();
    wr(12'hB00, 32'h100);
    step();
    wr(12'h320, 32'h5);
    chk("mci_old", 32'h0, 1'b1, 1'b0);
    step();
    wr(12'hB02, 32'h200);
    retire = 1'b1;
    step();
    idle();
    repeat (20) step();
    rd("inh_mcycle", 12'hB00, 32'h101);
    rd("inh_minstret", 12'hB02, 32'h200);
    rd("inh_reg", 12'h320, 32'h5);
    wr(12'h320, 32'h0);
    chk("inh_clr_old", 32'h5, 1'b1, 1'b0);
    step();
    rd("inh_hold_mcyc", 12'hB00, 32'h101);
    rd("inh_hold_minst", 12'hB02, 32'h200);
    step();
    rd("resume_mcyc", 12'hB00, 32'h102);
    rd("resume_minst", 12'hB02, 32'h201);
    wr(12'h320, 32'hFFFFFFFF);
    step();
    retire = 1'b0;
    rd("inh_mask", 12'h320, 32'h5);
`else
    step();
    wr(12'h320, 32'h5);
    chk("mci_absent", 32'h0, 1'b1, 1'b1);
`endif

    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
